// File: rtl/bomberman_pkg.sv
// Shared encodings for the Bomberman player datapath: facing codes, FSM states, tile width.
// The PLAYER_DEATH_EN macro adds the DEAD state to the FSM encoding.
package bomberman_pkg;

    localparam int TILE_W    = 4;
    localparam int MAP_W_DEF = 15;
    localparam int MAP_H_DEF = 13;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_QUERY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_COOL  = 3'd3
`ifdef PLAYER_DEATH_EN
        ,
        ST_DEAD  = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/move_cooldown_timer.sv
// Loadable down-counter that holds at zero; done is high whenever the count is zero.
module move_cooldown_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: flops use <= so every register samples pre-edge values together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/player_move_ctrl.sv
// Turns debounced buttons into validated grid moves with a cooldown, plus one-shot bomb requests.
// Optional macro PLAYER_DEATH_EN adds player_hit/player_dead and a terminal DEAD state.
module player_move_ctrl
    import bomberman_pkg::*;
#(
    parameter int MAP_W      = MAP_W_DEF,
    parameter int MAP_H      = MAP_H_DEF,
    parameter int START_X    = 0,
    parameter int START_Y    = 0,
    parameter int MOVE_DELAY = 25000000,
    parameter int CNT_W      = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_bomb,
    input  logic              map_blocked,
    input  logic              bomb_busy,
`ifdef PLAYER_DEATH_EN
    input  logic              player_hit,
    output logic              player_dead,
`endif
    output logic              query_en,
    output logic [TILE_W-1:0] query_x,
    output logic [TILE_W-1:0] query_y,
    output logic [TILE_W-1:0] player_x,
    output logic [TILE_W-1:0] player_y,
    output logic [1:0]        facing,
    output logic              move_done,
    output logic              bomb_req,
    output logic [TILE_W-1:0] bomb_x,
    output logic [TILE_W-1:0] bomb_y
);

    // One spare bit so a step below zero wraps to a value that fails the bounds check.
    localparam int EW = TILE_W + 1;
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(MOVE_DELAY - 1);

    state_t            state_q, state_d;
    logic [TILE_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [TILE_W-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [TILE_W-1:0] bomb_x_q, bomb_x_d, bomb_y_q, bomb_y_d;
    dir_t              facing_q, facing_d;
    logic              move_done_q, move_done_d;
    logic              bomb_req_q, bomb_req_d;
    logic              bomb_btn_q;
    logic              bomb_rise;

    logic              dir_any;
    dir_t              dir_sel;
    logic [EW-1:0]     cand_x, cand_y;
    logic              cand_ok;
    logic              tmr_load, tmr_dec, tmr_done;

    // Priority up > down > left > right; the candidate is one tile away on the chosen axis.
    always_comb begin
        dir_any = btn_up | btn_down | btn_left | btn_right;
        dir_sel = DIR_RIGHT;
        cand_x  = {1'b0, pos_x_q};
        cand_y  = {1'b0, pos_y_q};
        if (btn_up) begin
            dir_sel = DIR_UP;
            cand_y  = {1'b0, pos_y_q} - EW'(1);
        end else if (btn_down) begin
            dir_sel = DIR_DOWN;
            cand_y  = {1'b0, pos_y_q} + EW'(1);
        end else if (btn_left) begin
            dir_sel = DIR_LEFT;
            cand_x  = {1'b0, pos_x_q} - EW'(1);
        end else begin
            cand_x  = {1'b0, pos_x_q} + EW'(1);
        end
        // Odd/odd tiles are the fixed pillars of the classic grid.
        cand_ok = (cand_x < EW'(MAP_W)) && (cand_y < EW'(MAP_H)) && !(cand_x[0] && cand_y[0]);
    end

    assign bomb_rise = btn_bomb & ~bomb_btn_q;
    assign tmr_dec   = (state_q == ST_COOL);

    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        tgt_x_d     = tgt_x_q;
        tgt_y_d     = tgt_y_q;
        facing_d    = facing_q;
        move_done_d = 1'b0;
        tmr_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dir_any) begin
                    facing_d = dir_sel;
                    if (cand_ok) begin
                        tgt_x_d = cand_x[TILE_W-1:0];
                        tgt_y_d = cand_y[TILE_W-1:0];
                        state_d = ST_QUERY;
                    end
                end
            end
            ST_QUERY: state_d = ST_WAIT;
            ST_WAIT: begin
                if (map_blocked) begin
                    state_d = ST_IDLE;
                end else begin
                    pos_x_d     = tgt_x_q;
                    pos_y_d     = tgt_y_q;
                    move_done_d = 1'b1;
                    tmr_load    = 1'b1;
                    state_d     = ST_COOL;
                end
            end
            ST_COOL: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        bomb_req_d = bomb_rise & ~bomb_busy;

`ifdef PLAYER_DEATH_EN
        if (player_hit || (state_q == ST_DEAD)) begin
            state_d     = ST_DEAD;
            pos_x_d     = pos_x_q;
            pos_y_d     = pos_y_q;
            tgt_x_d     = tgt_x_q;
            tgt_y_d     = tgt_y_q;
            facing_d    = facing_q;
            move_done_d = 1'b0;
            tmr_load    = 1'b0;
            bomb_req_d  = 1'b0;
        end
`endif

        // Drop tile is the pre-edge position, so a same-edge move commit does not leak in.
        bomb_x_d = bomb_x_q;
        bomb_y_d = bomb_y_q;
        if (bomb_req_d) begin
            bomb_x_d = pos_x_q;
            bomb_y_d = pos_y_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pos_x_q     <= TILE_W'(START_X);
            pos_y_q     <= TILE_W'(START_Y);
            tgt_x_q     <= '0;
            tgt_y_q     <= '0;
            facing_q    <= DIR_DOWN;
            move_done_q <= 1'b0;
            bomb_req_q  <= 1'b0;
            bomb_x_q    <= '0;
            bomb_y_q    <= '0;
            bomb_btn_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            tgt_x_q     <= tgt_x_d;
            tgt_y_q     <= tgt_y_d;
            facing_q    <= facing_d;
            move_done_q <= move_done_d;
            bomb_req_q  <= bomb_req_d;
            bomb_x_q    <= bomb_x_d;
            bomb_y_q    <= bomb_y_d;
            bomb_btn_q  <= btn_bomb;
        end
    end

    move_cooldown_timer #(
        .CNT_W (CNT_W)
    ) u_cooldown (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (COOL_LOAD),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    assign query_en  = (state_q == ST_QUERY);
    assign query_x   = tgt_x_q;
    assign query_y   = tgt_y_q;
    assign player_x  = pos_x_q;
    assign player_y  = pos_y_q;
    assign facing    = facing_q;
    assign move_done = move_done_q;
    assign bomb_req  = bomb_req_q;
    assign bomb_x    = bomb_x_q;
    assign bomb_y    = bomb_y_q;
`ifdef PLAYER_DEATH_EN
    assign player_dead = (state_q == ST_DEAD);
`endif

endmodule
